// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit beside EX, writing HI/LO.
// Define EX_MULDIV_MACC_EN to add MADD/MSUB ({hi,lo} = hilo_i +/- op1*op2).
module ex_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               stallreq_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
`ifdef EX_MULDIV_MACC_EN
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
`endif

    localparam int W2   = 2 * WIDTH;
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 2);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [W2-1:0]    p_q [MUL_LAT];
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             in_mul, in_div, in_sgn, in_valid;
    logic             accept;
    logic [W2-1:0]    a_ext, b_ext, prod;
    logic [W2-1:0]    p_last, mul_res;
    logic [CW-1:0]    mul_end;
    logic             mul_last, div_zero, div_last;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] a_abs, b_abs;

`ifdef EX_MULDIV_MACC_EN
    logic             in_macc, in_sub;
    logic             macc_q, macc_d;
    logic             sub_q, sub_d;
    logic [W2-1:0]    hilo_q, hilo_d;
    logic [W2-1:0]    acc_q, acc_d;
`else
    logic             unused_hilo;
    assign unused_hilo = ^hilo_i;
`endif

    // Classify the incoming op code
    always_comb begin
        in_mul = 1'b0;
        in_div = 1'b0;
        in_sgn = 1'b0;
`ifdef EX_MULDIV_MACC_EN
        in_macc = 1'b0;
        in_sub  = 1'b0;
`endif
        unique case (op_i)
            OP_MULT: begin
                in_mul = 1'b1;
                in_sgn = 1'b1;
            end
            OP_MULTU: in_mul = 1'b1;
            OP_DIV: begin
                in_div = 1'b1;
                in_sgn = 1'b1;
            end
            OP_DIVU: in_div = 1'b1;
`ifdef EX_MULDIV_MACC_EN
            OP_MADD: begin
                in_mul  = 1'b1;
                in_sgn  = 1'b1;
                in_macc = 1'b1;
            end
            OP_MSUB: begin
                in_mul  = 1'b1;
                in_sgn  = 1'b1;
                in_macc = 1'b1;
                in_sub  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign in_valid   = in_mul | in_div;
    assign accept     = (state_q == S_IDLE) & start_i & in_valid & ~annul_i;
    assign busy_o     = (state_q != S_IDLE);
    assign stallreq_o = busy_o | (start_i & in_valid & ~annul_i & ~rst);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    // Full-width product formed from the operands as they are accepted
    always_comb begin
        a_ext = in_sgn ? {{WIDTH{op1_i[WIDTH-1]}}, op1_i}
                       : {{WIDTH{1'b0}}, op1_i};
        b_ext = in_sgn ? {{WIDTH{op2_i[WIDTH-1]}}, op2_i}
                       : {{WIDTH{1'b0}}, op2_i};
        prod  = a_ext * b_ext;
    end

    assign p_last = p_q[MUL_LAT-1];

`ifdef EX_MULDIV_MACC_EN
    assign mul_end = macc_q ? CW'(MUL_LAT) : CW'(MUL_LAT - 1);
    assign mul_res = macc_q ? acc_q : p_last;
`else
    assign mul_end = CW'(MUL_LAT - 1);
    assign mul_res = p_last;
`endif

    assign mul_last = (state_q == S_MUL) && (cnt_q == mul_end);
    assign div_zero = (state_q == S_DIV) && (cnt_q == '0) && (b_q == '0);
    assign div_last = (state_q == S_DIV) && (cnt_q == CW'(WIDTH));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; a flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = in_mul ? S_MUL : S_DIV;
            end
            S_MUL: begin
                if (mul_last) state_d = S_IDLE;
            end
            S_DIV: begin
                if (div_zero)      state_d = S_IDLE;
                else if (div_last) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (annul_i) state_d = S_IDLE;
    end

    // FSM outputs: done pulse and HI/LO update on completion only
    always_comb begin
        done_d = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (!annul_i) begin
            if (mul_last) begin
                done_d       = 1'b1;
                {hi_d, lo_d} = mul_res;
            end else if (div_zero) begin
                done_d = 1'b1;
                hi_d   = a_q;
                lo_d   = '1;
            end else if (state_q == S_FIX) begin
                done_d = 1'b1;
                lo_d   = neg_q  ? -quo_q : quo_q;
                hi_d   = rneg_q ? -rem_q : rem_q;
            end
        end
    end

    // Operand latch, cycle counter and restoring-divide datapath
    always_comb begin
        a_abs = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        trial = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};

        cnt_d  = (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
        a_d    = a_q;
        b_d    = b_q;
        sgn_d  = sgn_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;

        if (accept) begin
            cnt_d = '0;
            a_d   = op1_i;
            b_d   = op2_i;
            sgn_d = in_sgn;
        end

        if (state_q == S_DIV) begin
            if (cnt_q == '0) begin
                // setup cycle: work on magnitudes, remember result signs
                dvs_d  = b_abs;
                quo_d  = a_abs;
                rem_d  = '0;
                neg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d = sgn_q & a_q[WIDTH-1];
            end else if (!trial[WIDTH+1]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sgn_q  <= sgn_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Product pipeline: stage 0 loads at accept, then shifts each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) p_q[i] <= '0;
        end else begin
            if (accept) p_q[0] <= prod;
            for (int i = 1; i < MUL_LAT; i++) p_q[i] <= p_q[i-1];
        end
    end

`ifdef EX_MULDIV_MACC_EN
    // Accumulate control latched at accept; adder result one cycle behind
    always_comb begin
        macc_d = macc_q;
        sub_d  = sub_q;
        hilo_d = hilo_q;
        if (accept) begin
            macc_d = in_macc;
            sub_d  = in_sub;
            hilo_d = hilo_i;
        end
        acc_d = sub_q ? hilo_q - p_last : hilo_q + p_last;
    end

    // Accumulate registers
    always_ff @(posedge clk) begin
        if (rst) begin
            macc_q <= 1'b0;
            sub_q  <= 1'b0;
            hilo_q <= '0;
            acc_q  <= '0;
        end else begin
            macc_q <= macc_d;
            sub_q  <= sub_d;
            hilo_q <= hilo_d;
            acc_q  <= acc_d;
        end
    end
`endif

endmodule
